// File: rtl/pc_mt_rr.sv
// pc_mt_rr: round-robin multithreaded PC issue stage.
// Keeps one PC per hardware thread and issues one enabled thread per cycle,
// searching cyclically from a rotating pointer. A branch FIFO can redirect
// any thread's PC. Optional feature macro: PC_MT_BR_BYPASS_EN
// (same-cycle redirect bypass into the issued PC).
module pc_mt_rr #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     NUM_THREADS  = 8,
  parameter int unsigned     THREAD_WIDTH = $clog2(NUM_THREADS),
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic [NUM_THREADS-1:0]  thread_en_i,
  input  logic                    br_fifo_empty_i,
  input  logic [XLEN-1:0]         br_pc_i,
  input  logic [THREAD_WIDTH-1:0] br_thread_id_i,
  output logic                    br_ack_o,
  output logic [XLEN-1:0]         pc_o,
  output logic [THREAD_WIDTH-1:0] thread_id_o,
  output logic                    valid_o
);

  logic [XLEN-1:0]         pc_q [NUM_THREADS];
  logic [XLEN-1:0]         pc_d [NUM_THREADS];
  logic [THREAD_WIDTH-1:0] ptr_q, ptr_d;
  logic [XLEN-1:0]         pc_o_q, pc_o_d;
  logic [THREAD_WIDTH-1:0] tid_q, tid_d;
  logic                    valid_q, valid_d;

  logic [THREAD_WIDTH-1:0] sel;
  logic                    sel_found;
  logic                    redir_hit;

  // Redirect is popped whenever one is presented outside reset.
  assign br_ack_o  = !br_fifo_empty_i && !rst;
  // Out-of-range thread ids are popped but otherwise ignored.
  assign redir_hit = br_ack_o && (32'(br_thread_id_i) < NUM_THREADS);

  // Cyclic search for the first enabled thread starting at ptr_q.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      if (!sel_found &&
          thread_en_i[THREAD_WIDTH'((32'(ptr_q) + i) % NUM_THREADS)]) begin
        sel_found = 1'b1;
        sel       = THREAD_WIDTH'((32'(ptr_q) + i) % NUM_THREADS);
      end
    end
  end

  // Next-state: issue/increment, then redirect overrides the stored PC.
  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    pc_o_d  = pc_o_q;
    tid_d   = tid_q;
    valid_d = valid_q;
    if (!stall_i) begin
      if (sel_found) begin
        pc_o_d      = pc_q[sel];
        tid_d       = sel;
        valid_d     = 1'b1;
        pc_d[sel]   = pc_q[sel] + XLEN'(PC_STEP);
        ptr_d       = (sel == THREAD_WIDTH'(NUM_THREADS - 1)) ? '0 : sel + 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (redir_hit) begin
      pc_d[br_thread_id_i] = br_pc_i;
`ifdef PC_MT_BR_BYPASS_EN
      // Redirect to the thread being issued: forward the target now and
      // store the already-advanced PC so the next turn continues from it.
      if (!stall_i && sel_found && (br_thread_id_i == sel)) begin
        pc_o_d    = br_pc_i;
        pc_d[sel] = br_pc_i + XLEN'(PC_STEP);
      end
`else
      // Without bypass the old PC issues; the target is seen next turn.
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= RESET_PC;
      end
      ptr_q   <= '0;
      pc_o_q  <= RESET_PC;
      tid_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      pc_o_q  <= pc_o_d;
      tid_q   <= tid_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o        = pc_o_q;
  assign thread_id_o = tid_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_pc_mt_rr.sv
// Directed self-checking bench for pc_mt_rr (8 threads, step 4, reset PC 0).
module tb_pc_mt_rr;

`ifdef PC_MT_BR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [7:0]  thread_en_i;
  logic        br_fifo_empty_i;
  logic [31:0] br_pc_i;
  logic [2:0]  br_thread_id_i;
  logic        br_ack_o;
  logic [31:0] pc_o;
  logic [2:0]  thread_id_o;
  logic        valid_o;

  int checks = 0;
  int fails  = 0;

  pc_mt_rr #(
    .XLEN(32),
    .NUM_THREADS(8),
    .RESET_PC(32'h0),
    .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .thread_en_i(thread_en_i),
    .br_fifo_empty_i(br_fifo_empty_i),
    .br_pc_i(br_pc_i),
    .br_thread_id_i(br_thread_id_i),
    .br_ack_o(br_ack_o),
    .pc_o(pc_o),
    .thread_id_o(thread_id_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [2:0] tid, input logic [31:0] pc);
    step();
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".tid"}, 32'(thread_id_o), 32'(tid));
    chk({tag, ".pc"}, pc_o, pc);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; thread_en_i = 8'hFF;
    br_fifo_empty_i = 1'b0; br_pc_i = 32'h77; br_thread_id_i = 3'd1;
    #1;
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.pc", pc_o, 32'd0);
    chk("rst.tid", 32'(thread_id_o), 32'd0);
    chk("rst.ack", 32'(br_ack_o), 32'd0);
    step();
    br_fifo_empty_i = 1'b1;
    rst = 1'b0;

    // Two full rounds, all threads enabled.
    for (int k = 0; k < 16; k++) issue("rr", 3'(k % 8), 32'((k / 8) * 4));

    // Redirect thread 4 to 0x40 while thread 0 issues.
    br_fifo_empty_i = 1'b0; br_pc_i = 32'h40; br_thread_id_i = 3'd4;
    #1 chk("redir.ack", 32'(br_ack_o), 32'd1);
    issue("redir.t0", 3'd0, 32'h8);
    br_fifo_empty_i = 1'b1;
    #1 chk("redir.ack_off", 32'(br_ack_o), 32'd0);
    issue("redir.t1", 3'd1, 32'h8);
    issue("redir.t2", 3'd2, 32'h8);
    issue("redir.t3", 3'd3, 32'h8);
    issue("redir.t4a", 3'd4, 32'h40);
    issue("redir.t5", 3'd5, 32'h8);
    issue("redir.t6", 3'd6, 32'h8);
    issue("redir.t7", 3'd7, 32'h8);
    issue("redir.t0b", 3'd0, 32'hC);
    issue("redir.t1b", 3'd1, 32'hC);
    issue("redir.t2b", 3'd2, 32'hC);

    // Stall one cycle after thread 2 issues; redirect thread 5 meanwhile.
    stall_i = 1'b1;
    br_fifo_empty_i = 1'b0; br_pc_i = 32'h300; br_thread_id_i = 3'd5;
    #1 chk("stall.ack", 32'(br_ack_o), 32'd1);
    issue("stall.hold", 3'd2, 32'hC);
    stall_i = 1'b0; br_fifo_empty_i = 1'b1;
    issue("stall.t3", 3'd3, 32'hC);
    issue("stall.t4", 3'd4, 32'h44);

    // Sparse enables: threads 0 and 2 only (pointer currently 5).
    thread_en_i = 8'b0000_0101;
    issue("sparse.0a", 3'd0, 32'h10);
    issue("sparse.2a", 3'd2, 32'h10);
    issue("sparse.0b", 3'd0, 32'h14);
    issue("sparse.2b", 3'd2, 32'h14);

    // Nothing enabled; redirect the disabled thread 1.
    thread_en_i = 8'h00;
    br_fifo_empty_i = 1'b0; br_pc_i = 32'h200; br_thread_id_i = 3'd1;
    step();
    chk("idle.valid", 32'(valid_o), 32'd0);
    br_fifo_empty_i = 1'b1;
    step();
    chk("idle.valid2", 32'(valid_o), 32'd0);

    // Re-enable all (pointer 3) and redirect the thread being selected.
    thread_en_i = 8'hFF;
    br_fifo_empty_i = 1'b0; br_pc_i = 32'h100; br_thread_id_i = 3'd3;
    issue("same.t3", 3'd3, BYP ? 32'h100 : 32'h10);
    br_fifo_empty_i = 1'b1;
    issue("same.t4", 3'd4, 32'h48);
    issue("same.t5", 3'd5, 32'h300);
    issue("same.t6", 3'd6, 32'hC);
    issue("same.t7", 3'd7, 32'hC);
    issue("same.t0", 3'd0, 32'h18);
    issue("same.t1", 3'd1, 32'h200);
    issue("same.t2", 3'd2, 32'h18);
    issue("same.t3b", 3'd3, BYP ? 32'h104 : 32'h100);

    // Asynchronous reset mid-round with a redirect pending.
    br_fifo_empty_i = 1'b0; br_pc_i = 32'h500; br_thread_id_i = 3'd0;
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 32'(valid_o), 32'd0);
    chk("arst.pc", pc_o, 32'd0);
    chk("arst.tid", 32'(thread_id_o), 32'd0);
    chk("arst.ack", 32'(br_ack_o), 32'd0);
    step();
    br_fifo_empty_i = 1'b1;
    rst = 1'b0;
    issue("post.t0", 3'd0, 32'h0);
    issue("post.t1", 3'd1, 32'h0);
    issue("post.t2", 3'd2, 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
